pc_next_unit: RTL and testbench

//  Parametrised program-counter unit for the single-cycle/pipelined CPU datapath.

---
 rtl/pc_pkg.sv | 26 ++
 rtl/pc_next_unit_if.sv | 32 +++
 rtl/pc_ras.sv | 48 ++++
 rtl/pc_next_unit.sv | 95 +++++++++
 tb/tb_pc_next_unit.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit.
package pc_pkg;

   typedef enum logic [1:0] {
      PC_SEQ,
      PC_BRANCH,
      PC_JUMP,
      PC_RET
   } pc_sel_e;

   // Pseudo-direct jump target: low bits from the instruction field, the rest
   // from pc+1. When the PC is no wider than the field, the field covers it all.
   // Operands are zero-extended to 64 bits so the helper stays width-agnostic.
   function automatic logic [63:0] jump_concat(input logic [63:0] next_pc,
                                               input logic [63:0] target,
                                               input int unsigned addr_w,
                                               input int unsigned jump_w);
      logic [63:0] tmask;
      tmask = '0;
      for (int unsigned i = 0; i < 64; i++) begin
         if (i < jump_w && i < addr_w) tmask[i] = 1'b1;
      end
      return (next_pc & ~tmask) | (target & tmask);
   endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// Control/status bundle between the control unit and the PC unit.
interface pc_next_unit_if #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned JUMP_W    = 26,
   parameter int unsigned RAS_DEPTH = 4
);
   localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

   logic              stall;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_off;
   logic              jump;
   logic [JUMP_W-1:0] jump_target;
   logic              link;
   logic              ret;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus1;
   logic [CW-1:0]     ras_count;
   logic              ras_overflow;
   logic              ras_underflow;

   modport master (
      output stall, branch_taken, branch_off, jump, jump_target, link, ret,
      input  pc, pc_plus1, ras_count, ras_overflow, ras_underflow
   );

   modport slave (
      input  stall, branch_taken, branch_off, jump, jump_target, link, ret,
      output pc, pc_plus1, ras_count, ras_overflow, ras_underflow
   );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               top,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] ptr;
   logic [CW-1:0] count_q;
   logic          ovf_q;

   // ptr names the next free slot; wrapping it makes overwrite-on-full free
   assign top      = mem[ptr - PW'(1)];
   assign count    = count_q;
   assign overflow = ovf_q;

   // Pointer, occupancy and sticky overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr     <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else if (push) begin
         ptr <= ptr + PW'(1);
         if (count_q == CW'(DEPTH)) ovf_q   <= 1'b1;
         else                       count_q <= count_q + CW'(1);
      end else if (pop) begin
         ptr     <= ptr - PW'(1);
         count_q <= count_q - CW'(1);
      end
   end

   // Entry storage; contents need no reset since count gates validity
   always_ff @(posedge clk) begin
      if (push && !reset) mem[ptr] <= din;
   end
endmodule

// File: rtl/pc_next_unit.sv
// Program-counter unit: next-PC selection, PC register and return-address stack.
module pc_next_unit
   import pc_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       JUMP_W    = 26,
   parameter int unsigned       RAS_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input logic            clk,
   input logic            reset,
   pc_next_unit_if.slave  bus
);
   localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] pc_plus1;
   logic [ADDR_W-1:0] jump_pc;
   logic [ADDR_W-1:0] ras_top;
   logic [CW-1:0]     ras_count;
   logic              ras_ovf;
   logic              push;
   logic              pop;
   logic              unf_d;
   logic              unf_q;
   pc_sel_e           sel;

   assign pc_plus1 = pc_q + ADDR_W'(1);
   assign jump_pc  = ADDR_W'(jump_concat(64'(pc_plus1), 64'(bus.jump_target),
                                         ADDR_W, JUMP_W));

   pc_ras #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pop      (pop),
      .din      (pc_plus1),
      .top      (ras_top),
      .count    (ras_count),
      .overflow (ras_ovf)
   );

   // Priority encode requests (stall > ret > jump > branch > sequential)
   always_comb begin
      sel   = PC_SEQ;
      push  = 1'b0;
      pop   = 1'b0;
      unf_d = 1'b0;
      if (!bus.stall) begin
         if (bus.ret) begin
            if (ras_count != '0) begin
               sel = PC_RET;
               pop = 1'b1;
            end else begin
               unf_d = 1'b1;
            end
         end else if (bus.jump) begin
            sel  = PC_JUMP;
            push = bus.link;
         end else if (bus.branch_taken) begin
            sel = PC_BRANCH;
         end
      end
   end

   // Next-PC mux
   always_comb begin
      pc_d = pc_plus1;
      case (sel)
         PC_SEQ:    pc_d = pc_plus1;
         PC_BRANCH: pc_d = pc_plus1 + bus.branch_off;
         PC_JUMP:   pc_d = jump_pc;
         PC_RET:    pc_d = ras_top;
         default:   pc_d = pc_plus1;
      endcase
   end

   // PC register and underflow pulse; stall freezes the PC and suppresses the pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= RESET_PC;
         unf_q <= 1'b0;
      end else begin
         if (!bus.stall) pc_q <= pc_d;
         unf_q <= unf_d;
      end
   end

   assign bus.pc            = pc_q;
   assign bus.pc_plus1      = pc_plus1;
   assign bus.ras_count     = ras_count;
   assign bus.ras_overflow  = ras_ovf;
   assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed scoreboard bench for pc_next_unit (ADDR_W=32, JUMP_W=26, RAS_DEPTH=4).
module tb_pc_next_unit;
   localparam int unsigned DEPTH = 4;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic [2:0]  cnt;
      logic        ovf;
      logic        unf;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;

   exp_t        sb[$];
   logic [31:0] mras[$];
   logic [31:0] mpc  = '0;
   logic        movf = 1'b0;
   logic        munf = 1'b0;

   pc_next_unit_if #(.ADDR_W(32), .JUMP_W(26), .RAS_DEPTH(DEPTH)) bus ();

   pc_next_unit #(
      .ADDR_W    (32),
      .JUMP_W    (26),
      .RAS_DEPTH (DEPTH),
      .RESET_PC  (32'h0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle of requests, predict the result, then compare after the edge
   task automatic step(input string tag, input logic rst, input logic st,
                       input logic br, input logic [31:0] off,
                       input logic j, input logic [25:0] tgt,
                       input logic l, input logic r);
      exp_t        e;
      logic [31:0] n;
      reset            = rst;
      bus.stall        = st;
      bus.branch_taken = br;
      bus.branch_off   = off;
      bus.jump         = j;
      bus.jump_target  = tgt;
      bus.link         = l;
      bus.ret          = r;

      n = mpc + 32'd1;
      if (rst) begin
         mpc = '0; mras.delete(); movf = 1'b0; munf = 1'b0;
      end else if (st) begin
         munf = 1'b0;
      end else if (r) begin
         if (mras.size() > 0) begin
            mpc = mras.pop_back(); munf = 1'b0;
         end else begin
            mpc = n; munf = 1'b1;
         end
      end else if (j) begin
         if (l) begin
            if (mras.size() == DEPTH) begin
               void'(mras.pop_front());
               movf = 1'b1;
            end
            mras.push_back(n);
         end
         mpc  = {n[31:26], tgt};
         munf = 1'b0;
      end else if (br) begin
         mpc = n + off; munf = 1'b0;
      end else begin
         mpc = n; munf = 1'b0;
      end

      e.tag = tag; e.pc = mpc; e.cnt = 3'(mras.size()); e.ovf = movf; e.unf = munf;
      sb.push_back(e);

      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.tag, ".pc"},       bus.pc,                    e.pc);
      check({e.tag, ".pc_plus1"}, bus.pc_plus1,              e.pc + 32'd1);
      check({e.tag, ".count"},    32'(bus.ras_count),        32'(e.cnt));
      check({e.tag, ".ovf"},      32'(bus.ras_overflow),     32'(e.ovf));
      check({e.tag, ".unf"},      32'(bus.ras_underflow),    32'(e.unf));
   endtask

   task automatic seq(input string tag);
      step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0);
   endtask

   task automatic brn(input string tag, input logic [31:0] off);
      step(tag, 1'b0, 1'b0, 1'b1, off, 1'b0, 26'h0, 1'b0, 1'b0);
   endtask

   task automatic jmp(input string tag, input logic [25:0] tgt, input logic l);
      step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, tgt, l, 1'b0);
   endtask

   task automatic rtn(input string tag);
      step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b1);
   endtask

   // Reach an arbitrary PC with a single relative branch
   task automatic go_to(input string tag, input logic [31:0] target);
      brn(tag, target - mpc - 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset and sequential fetch
      step("rst0", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0);
      step("rst1", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0);
      seq("seq1");
      seq("seq2");
      seq("seq3");
      if (mpc != 32'd3) $display("FAIL model_seq: observed %0d expected 3", mpc);

      // branches, including offset ignored without strobe
      go_to("goto10a", 32'd10);
      brn("br_m4", 32'hFFFF_FFFC);
      go_to("goto10b", 32'd10);
      brn("br_p5", 32'd5);
      step("br_off_nostrobe", 1'b0, 1'b0, 1'b0, 32'd100, 1'b0, 26'h3FF_FFFF, 1'b0, 1'b0);

      // pseudo-direct jump keeps upper bits of pc+1; sequential wrap
      go_to("goto_hi", 32'h3000_0010);
      jmp("jump_hi", 26'h000_0100, 1'b0);
      go_to("goto_max", 32'hFFFF_FFFF);
      seq("wrap");

      // jal five times into a 4-deep stack, then drain and underflow
      go_to("goto5", 32'd5);
      jmp("jal5", 26'd6, 1'b1);
      jmp("jal6", 26'd7, 1'b1);
      jmp("jal7", 26'd8, 1'b1);
      jmp("jal8", 26'd9, 1'b1);
      jmp("jal9", 26'd100, 1'b1);
      rtn("ret10");
      rtn("ret9");
      rtn("ret8");
      rtn("ret7");
      rtn("ret_empty");
      seq("after_unf");
      step("link_only", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h55, 1'b1, 1'b0);

      // stall holds everything and drops requests
      go_to("goto20", 32'd20);
      step("stall_jump", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 26'h123, 1'b1, 1'b0);
      step("stall_ret", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b1);
      seq("resume");

      // ret beats jump+link; mid-sequence reset empties the stack
      go_to("goto39", 32'd39);
      jmp("jal39", 26'd50, 1'b1);
      step("ret_jl", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h77, 1'b1, 1'b1);
      jmp("jal_a", 26'd60, 1'b1);
      jmp("jal_b", 26'd70, 1'b1);
      step("rst_mid", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0);
      rtn("ret_after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
